// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep capture block:
// FSM state encoding and the optional signature MISR constants.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        EMIT   = 2'd3
    } state_t;

    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

    // One MISR step: shift left, fold the polynomial in on carry-out, then mix in the new data.
    function automatic logic [31:0] misr_step(input logic [31:0] state, input logic [31:0] data);
        return {state[30:0], 1'b0} ^ (state[31] ? MISR_POLY : 32'h0) ^ data;
    endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Truth-table word stream: one captured word per DUT output, valid/ready handshake.
interface tt_sweep_capture_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 6
);
    localparam int TT_W  = 1 << N_IN;
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic [TT_W-1:0]  tt_data;
    logic [IDX_W-1:0] tt_idx;
    logic             tt_valid;
    logic             tt_ready;

    modport master (output tt_data, output tt_idx, output tt_valid, input tt_ready);
    modport slave  (input tt_data, input tt_idx, input tt_valid, output tt_ready);

endinterface

// File: rtl/tt_misr.sv
// 32-bit multiple-input signature register over the sampled DUT outputs.
module tt_misr
    import tt_sweep_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] data,
    output logic [31:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= 32'h0;
        end else if (load) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= misr_step(sig, data);
        end
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps every input vector of a combinational DUT and streams one truth-table word per output.
// Optional signature port enabled by defining TT_SWEEP_SIG_EN.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 6,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   x,
    input  logic [N_OUT-1:0]  f,
    output logic              busy,
    output logic              done,
`ifdef TT_SWEEP_SIG_EN
    output logic [31:0]       sig,
`endif
    tt_sweep_capture_if.master tt
);

    localparam int TT_W  = 1 << N_IN;
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [N_IN-1:0]  X_LAST      = '1;
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_OUT - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       settle_cnt;
    logic [TT_W-1:0]  cap [N_OUT];
    logic [IDX_W-1:0] idx_nxt;
    logic             last_xfer;

    assign idx_nxt   = tt.tt_idx + 1'b1;
    assign last_xfer = (state == EMIT) && tt.tt_valid && tt.tt_ready && (tt.tt_idx == IDX_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (x == X_LAST) ? EMIT : DRIVE;
            EMIT:    if (last_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first EMIT cycle only loads word 0; afterwards each transfer loads the next word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            settle_cnt  <= 4'd0;
            done        <= 1'b0;
            tt.tt_valid <= 1'b0;
            tt.tt_data  <= '0;
            tt.tt_idx   <= '0;
            for (int j = 0; j < N_OUT; j++) cap[j] <= '0;
        end else begin
            done <= last_xfer;
            case (state)
                IDLE: begin
                    if (start) begin
                        x          <= '0;
                        settle_cnt <= 4'd0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    for (int j = 0; j < N_OUT; j++) cap[j][x] <= f[j];
                    if (x != X_LAST) x <= x + 1'b1;
                end
                EMIT: begin
                    if (!tt.tt_valid) begin
                        tt.tt_valid <= 1'b1;
                        tt.tt_data  <= cap[0];
                        tt.tt_idx   <= '0;
                    end else if (tt.tt_ready) begin
                        if (tt.tt_idx == IDX_LAST) begin
                            tt.tt_valid <= 1'b0;
                        end else begin
                            tt.tt_idx  <= idx_nxt;
                            tt.tt_data <= cap[idx_nxt];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TT_SWEEP_SIG_EN
    tt_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  ((state == IDLE) && start),
        .en    (state == SAMPLE),
        .data  (32'(f)),
        .sig   (sig)
    );
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Scoreboard bench for tt_sweep_capture: directed sweeps plus randomized truth tables and backpressure.
// Signature checks are compiled in when TT_SWEEP_SIG_EN is defined.
module tb_tt_sweep_capture;

    logic       clk;
    logic       rst_n;
    logic       start1, start3;
    logic [1:0] x1, x3;
    logic [5:0] f1, f3;
    logic       busy1, busy3, done1, done3;
`ifdef TT_SWEEP_SIG_EN
    logic [31:0] sig1, sig3;
`endif

    tt_sweep_capture_if #(.N_IN(2), .N_OUT(6)) ifc1 ();
    tt_sweep_capture_if #(.N_IN(2), .N_OUT(6)) ifc3 ();

    tt_sweep_capture #(.N_IN(2), .N_OUT(6), .SETTLE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .x     (x1),
        .f     (f1),
        .busy  (busy1),
        .done  (done1),
`ifdef TT_SWEEP_SIG_EN
        .sig   (sig1),
`endif
        .tt    (ifc1.master)
    );

    tt_sweep_capture #(.N_IN(2), .N_OUT(6), .SETTLE(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .x     (x3),
        .f     (f3),
        .busy  (busy3),
        .done  (done3),
`ifdef TT_SWEEP_SIG_EN
        .sig   (sig3),
`endif
        .tt    (ifc3.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          fmode;
    logic [23:0] lut_flat;
    int          rdy_mode;
    int          stall_cnt, stall_seen;
    int          valid_cnt1, words1, done_cnt1, done_cyc1;
    int          words3, done_cnt3, done_cyc3;
    logic [15:0] q1[$];
    logic [15:0] q3[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference DUT: spec functions in mode 0, random lookup tables otherwise.
    function automatic logic fbit(input int mode, input logic [23:0] lut, input int j, input int xi);
        logic a, b;
        a = xi[0];
        b = xi[1];
        if (mode != 0) return lut[j*4 + xi];
        case (j)
            0:       return a;
            1:       return b;
            2:       return a & b;
            3:       return a | b;
            4:       return ~a & ~b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [3:0] exp_word(input int j);
        logic [3:0] w;
        for (int i = 0; i < 4; i++) w[i] = fbit(fmode, lut_flat, j, i);
        return w;
    endfunction

    function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [31:0] d);
        logic c;
        c = s[31];
        s = s << 1;
        if (c) s = s ^ 32'h04C1_1DB7;
        return s ^ d;
    endfunction

    function automatic logic [31:0] golden_sig();
        logic [31:0] s, d;
        s = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            d = '0;
            for (int j = 0; j < 6; j++) d[j] = fbit(fmode, lut_flat, j, i);
            s = misr_ref(s, d);
        end
        return s;
    endfunction

    always_comb begin
        f1 = '0;
        for (int j = 0; j < 6; j++) f1[j] = fbit(fmode, lut_flat, j, int'(x1));
    end
    assign f3 = 6'h3F;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: ifc1.tt_ready = 1'b1;
            1: ifc1.tt_ready = 1'($urandom_range(0, 1));
            default: begin
                if (ifc1.tt_valid && ifc1.tt_idx == 3'd2 && stall_cnt < 3) begin
                    ifc1.tt_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    ifc1.tt_ready = 1'b1;
                end
            end
        endcase
    end

    // Monitor for the SETTLE=1 instance: scoreboard pops, hold-under-stall and done tracking.
    logic [3:0] prev_data;
    logic [2:0] prev_idx;
    bit         held = 0;
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst_n) begin
            held = 0;
        end else begin
            if (held) begin
                chk("hold_valid", ifc1.tt_valid, 1);
                chk("hold_data", ifc1.tt_data, prev_data);
                chk("hold_idx", ifc1.tt_idx, prev_idx);
            end
            if (ifc1.tt_valid) valid_cnt1++;
            if (rdy_mode == 2 && ifc1.tt_valid && !ifc1.tt_ready) begin
                stall_seen++;
                chk("stall_data", ifc1.tt_data, 4'b1000);
                chk("stall_idx", ifc1.tt_idx, 2);
            end
            if (ifc1.tt_valid && ifc1.tt_ready) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got idx %0d data %0h, expected none", ifc1.tt_idx, ifc1.tt_data);
                end else begin
                    e = q1.pop_front();
                    chk("word_idx", ifc1.tt_idx, e[15:8]);
                    chk("word_data", ifc1.tt_data, e[7:0]);
                end
                words1++;
            end
            held      = ifc1.tt_valid && !ifc1.tt_ready;
            prev_data = ifc1.tt_data;
            prev_idx  = ifc1.tt_idx;
            if (done1) begin
                done_cnt1++;
                done_cyc1 = cyc;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            if (ifc3.tt_valid && ifc3.tt_ready) begin
                if (q3.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL s3_unexpected_word: got idx %0d data %0h, expected none", ifc3.tt_idx, ifc3.tt_data);
                end else begin
                    e = q3.pop_front();
                    chk("s3_word_idx", ifc3.tt_idx, e[15:8]);
                    chk("s3_word_data", ifc3.tt_data, e[7:0]);
                end
                words3++;
            end
            if (done3) begin
                done_cnt3++;
                done_cyc3 = cyc;
            end
        end
    end

    task automatic pulse_start1(output int sc);
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        sc = cyc;
    endtask

    task automatic run_sweep1(input int rmode, input int lat_exp, input bit extra);
        int sc, wbase, dbase;
        rdy_mode   = rmode;
        stall_cnt  = 0;
        stall_seen = 0;
        for (int j = 0; j < 6; j++) q1.push_back({8'(j), 8'(exp_word(j))});
        wbase = words1;
        dbase = done_cnt1;
        pulse_start1(sc);
        if (extra) begin
            chk("busy_after_start", busy1, 1);
            start1 = 1'b1;
            @(posedge clk);
            #1 start1 = 1'b0;
        end
        for (int k = 0; k < 200 && done_cnt1 == dbase; k++) @(posedge clk);
        if (lat_exp > 0) chk("done_latency", done_cyc1 - sc, lat_exp);
        repeat (5) @(posedge clk);
        chk("done_pulses", done_cnt1 - dbase, 1);
        chk("word_count", words1 - wbase, 6);
        chk("busy_idle", busy1, 0);
        chk("queue_left", q1.size(), 0);
        q1.delete();
    endtask

    initial begin
        int sc, dbase, wbase, vbase;
        logic [31:0] g, prev;
        start1 = 1'b0;
        start3 = 1'b0;
        rst_n = 1'b1;
        fmode = 0;
        lut_flat = '0;
        rdy_mode = 0;
        ifc3.tt_ready = 1'b1;
        g = '0;
        prev = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_x", x1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_valid", ifc1.tt_valid, 0);
        chk("rst_done", done1, 0);
        chk("rst_data", ifc1.tt_data, 0);
        chk("rst_idx", ifc1.tt_idx, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Spec functions, ready held high, then a 3-cycle stall on word 2, then an ignored restart.
        run_sweep1(0, 15, 0);
        run_sweep1(2, 18, 0);
        chk("stall_cycles", stall_seen, 3);
        run_sweep1(0, 15, 1);

        // Reset during SAMPLE of vector 2.
        rdy_mode = 0;
        pulse_start1(sc);
        repeat (5) @(posedge clk);
        #2;
        chk("pre_reset_x", x1, 2);
        chk("pre_reset_busy", busy1, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_x", x1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_valid", ifc1.tt_valid, 0);
        chk("mid_rst_done", done1, 0);
        chk("mid_rst_data", ifc1.tt_data, 0);
        chk("mid_rst_idx", ifc1.tt_idx, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        vbase = valid_cnt1;
        repeat (30) @(posedge clk);
        chk("no_valid_after_reset", valid_cnt1 - vbase, 0);
        chk("idle_after_reset", busy1, 0);
        run_sweep1(0, 15, 0);

        // SETTLE=3 instance with a constant-high DUT.
        for (int j = 0; j < 6; j++) q3.push_back({8'(j), 8'h0F});
        dbase = done_cnt3;
        wbase = words3;
        @(posedge clk);
        #1 start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        sc = cyc;
        for (int k = 0; k < 200 && done_cnt3 == dbase; k++) @(posedge clk);
        chk("s3_done_latency", done_cyc3 - sc, 23);
        repeat (5) @(posedge clk);
        chk("s3_done_pulses", done_cnt3 - dbase, 1);
        chk("s3_word_count", words3 - wbase, 6);
        chk("s3_queue_left", q3.size(), 0);
`ifdef TT_SWEEP_SIG_EN
        g = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) g = misr_ref(g, 32'h3F);
        chk("s3_sig", sig3, g);
`endif

        // Random truth tables with random or continuous backpressure.
        fmode = 1;
        for (int r = 0; r < 8; r++) begin
            lut_flat = 24'($urandom);
            if (r % 2 == 0) run_sweep1(1, 0, 0);
            else run_sweep1(0, 15, 0);
`ifdef TT_SWEEP_SIG_EN
            g = golden_sig();
            chk("sig", sig1, g);
            prev = sig1;
            run_sweep1(1, 0, 0);
            chk("sig_repeat", sig1, prev);
            chk("sig_repeat_golden", sig1, g);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tt_sweep_capture.md
TT_SWEEP_CAPTURE -- requirements
Module: tt_sweep_capture

Interface
REQ-001 The block SHALL have parameter N_IN, default 2, giving the width of the vector driven into the combinational DUT (range 1..8).
REQ-002 The block SHALL have parameter N_OUT, default 6, giving the number of DUT outputs captured (range 1..32).
REQ-003 The block SHALL have parameter SETTLE, default 1, giving the number of cycles waited between driving a vector and sampling the DUT outputs (range 1..15).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port start, input, 1 bit: one-cycle pulse that begins a sweep; ignored unless the FSM is in IDLE.
REQ-008 Port x, output, N_IN bits: vector driven into the DUT inputs.
REQ-009 Port f, input, N_OUT bits: DUT outputs.
REQ-010 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 Port tt_data, output, 2^N_IN bits: truth-table word for one DUT output.
REQ-012 Port tt_idx, output, ceil(log2(N_OUT)) bits: index of the DUT output that the current word belongs to.
REQ-013 Port tt_valid, output, 1 bit: high while tt_data and tt_idx are valid.
REQ-014 Port tt_ready, input, 1 bit: consumer accepts the current word.
REQ-015 Port done, output, 1 bit: one-cycle pulse after the last word has been accepted.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, DRIVE, SAMPLE, EMIT.
- IDLE -> DRIVE on start; x is cleared to 0.
- DRIVE counts SETTLE cycles with x held, then goes to SAMPLE.
- SAMPLE is one cycle: f[j] is written to bit x of capture word j, for every j.
- After SAMPLE: if x == 2^N_IN-1, go to EMIT; otherwise increment x and return to DRIVE.
REQ-017 Truth-table bit i of word j SHALL equal f[j] when x == i; x0 is the LSB of x.
REQ-018 In EMIT the block SHALL present words j = 0..N_OUT-1 in ascending order, with tt_valid held high.
- A word is transferred on a cycle where tt_valid and tt_ready are both high.
- tt_data and tt_idx SHALL NOT change while tt_valid is high and tt_ready is low.
REQ-019 After the transfer of word N_OUT-1, the block SHALL pulse done for one cycle and enter IDLE on the same edge.
REQ-020 A start pulse while busy is high SHALL be ignored, with no effect on the sweep in progress.
REQ-021 tt_ready asserted outside EMIT SHALL have no effect.
REQ-022 A full sweep with tt_ready held high SHALL take exactly 1 + 2^N_IN·(SETTLE+1) + N_OUT cycles from the start edge to the done pulse.
REQ-023 The vector counter SHALL NOT wrap past 2^N_IN-1 within a sweep.

Reset
REQ-024 While rst_n is low, the block SHALL force the following, independent of clk: FSM=IDLE, x=0, busy=0, tt_valid=0, done=0, tt_data=0, tt_idx=0, all capture words=0, settle counter=0.
REQ-025 If reset is asserted mid-sweep or mid-EMIT, the sweep SHALL be abandoned and no partial word SHALL be emitted after reset deasserts.

Configuration
REQ-026 With TT_SWEEP_SIG_EN defined, the block SHALL add port sig, output, 32 bits.
- sig is a MISR, polynomial 0x04C11DB7, seed 0xFFFFFFFF.
- The MISR is loaded with the seed on start and updated in each SAMPLE cycle with f zero-extended to 32 bits.
- sig is stable from the done pulse until the next start.
REQ-027 Without TT_SWEEP_SIG_EN, the sig port and the MISR logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-028 The FSM state enum and the MISR polynomial and seed constants SHALL live in the shared package tt_sweep_pkg.
REQ-029 The MISR SHALL be a sub-module tt_misr, instantiated only when TT_SWEEP_SIG_EN is defined.

Verification
REQ-030 The bench SHALL cover these directed scenarios (N_IN=2, N_OUT=6, SETTLE=1, DUT for f0..f5 = x0, x1, x0&x1, x0|x1, ~x0&~x1, x0^x1):
- Start with tt_ready=1 -> words 0..5 = 4'b1010, 4'b1100, 4'b1000, 4'b1110, 4'b0001, 4'b0110; done pulses 15 cycles after the start edge.
- tt_ready low for 3 cycles on word 2 -> tt_data holds 4'b1000 and tt_idx holds 2 throughout; the sequence then resumes in order.
- Second start pulse issued during DRIVE -> ignored; exactly 6 words are emitted.
- rst_n pulsed low during SAMPLE with x=2 -> all outputs 0 immediately; no tt_valid until the next start.
- SETTLE=3, constant DUT f=6'h3F -> all six words = 4'b1111; done 23 cycles after the start edge.
- With TT_SWEEP_SIG_EN -> sig equals the golden MISR model value, and repeats identically on a second sweep.
